// File: rtl/sdram_req_arbiter.sv
// Write/read burst arbiter in front of the SDRAM controller: issues bursts when the FIFOs allow,
// alternates on contention, and walks circular address pointers inside programmable windows.
module sdram_req_arbiter #(
  parameter int ADDR_W = 24,
  parameter int LVL_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sdram_init_done,
  input  logic [LVL_W-1:0]  wr_fifo_level,
  input  logic [LVL_W-1:0]  rd_fifo_room,
  input  logic              rd_enable,
  input  logic [LVL_W-1:0]  wr_burst_len,
  input  logic [LVL_W-1:0]  rd_burst_len,
  input  logic [ADDR_W-1:0] wr_min_addr,
  input  logic [ADDR_W-1:0] wr_max_addr,
  input  logic [ADDR_W-1:0] rd_min_addr,
  input  logic [ADDR_W-1:0] rd_max_addr,
  input  logic              wr_load,
  input  logic              rd_load,
  output logic              sdram_wr_req,
  output logic              sdram_rd_req,
  input  logic              sdram_wr_ack,
  input  logic              sdram_rd_ack,
  output logic [ADDR_W-1:0] sdram_wr_addr,
  output logic [ADDR_W-1:0] sdram_rd_addr,
  output logic [LVL_W-1:0]  sdram_wr_burst,
  output logic [LVL_W-1:0]  sdram_rd_burst,
  output logic              busy
);

  localparam int PAD = ADDR_W + 1 - LVL_W;
  localparam logic [ADDR_W:0] ONE = 1;

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_ACT, RD_REQ, RD_ACT} state_t;

  state_t state, state_nxt;

  logic              last_wr;
  logic              wr_elig, rd_elig;
  logic              wr_grant, rd_grant;
  logic              wr_done, rd_done;
  logic              wr_busy, rd_busy;
  logic              wr_load_pend, rd_load_pend;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   wr_nxt, wr_end, wr_lim;
  logic [ADDR_W:0]   rd_nxt, rd_end, rd_lim;

  assign wr_elig = sdram_init_done && (wr_burst_len != '0) && (wr_fifo_level >= wr_burst_len);
  assign rd_elig = sdram_init_done && rd_enable && (rd_burst_len != '0) &&
                   (rd_fifo_room >= rd_burst_len);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // On contention the direction that did not win last time is granted.
  always_comb begin
    state_nxt = state;
    wr_grant  = 1'b0;
    rd_grant  = 1'b0;
    case (state)
      IDLE: begin
        if (wr_elig && (!rd_elig || !last_wr)) begin
          state_nxt = WR_REQ;
          wr_grant  = 1'b1;
        end else if (rd_elig) begin
          state_nxt = RD_REQ;
          rd_grant  = 1'b1;
        end
      end
      WR_REQ:  if (sdram_wr_ack)  state_nxt = WR_ACT;
      WR_ACT:  if (!sdram_wr_ack) state_nxt = IDLE;
      RD_REQ:  if (sdram_rd_ack)  state_nxt = RD_ACT;
      RD_ACT:  if (!sdram_rd_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign wr_done = (state == WR_ACT) && !sdram_wr_ack;
  assign rd_done = (state == RD_ACT) && !sdram_rd_ack;
  assign wr_busy = (state == WR_REQ) || (state == WR_ACT);
  assign rd_busy = (state == RD_REQ) || (state == RD_ACT);

  // Wrap early so the following burst can never run past the window end.
  assign wr_nxt = {1'b0, wr_ptr} + {{PAD{1'b0}}, sdram_wr_burst};
  assign wr_end = wr_nxt + {{PAD{1'b0}}, sdram_wr_burst};
  assign wr_lim = {1'b0, wr_max_addr} + ONE;
  assign rd_nxt = {1'b0, rd_ptr} + {{PAD{1'b0}}, sdram_rd_burst};
  assign rd_end = rd_nxt + {{PAD{1'b0}}, sdram_rd_burst};
  assign rd_lim = {1'b0, rd_max_addr} + ONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_wr        <= 1'b0;
      sdram_wr_burst <= '0;
      sdram_rd_burst <= '0;
    end else if (wr_grant) begin
      last_wr        <= 1'b1;
      sdram_wr_burst <= wr_burst_len;
    end else if (rd_grant) begin
      last_wr        <= 1'b0;
      sdram_rd_burst <= rd_burst_len;
    end
  end

  // A load during the pointer's own transaction is deferred so the address stays stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= wr_min_addr;
      wr_load_pend <= 1'b0;
    end else if (wr_done) begin
      wr_load_pend <= 1'b0;
      if (wr_load || wr_load_pend || (wr_end > wr_lim)) wr_ptr <= wr_min_addr;
      else                                              wr_ptr <= wr_nxt[ADDR_W-1:0];
    end else if (wr_load) begin
      if (wr_busy) wr_load_pend <= 1'b1;
      else         wr_ptr       <= wr_min_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr       <= rd_min_addr;
      rd_load_pend <= 1'b0;
    end else if (rd_done) begin
      rd_load_pend <= 1'b0;
      if (rd_load || rd_load_pend || (rd_end > rd_lim)) rd_ptr <= rd_min_addr;
      else                                              rd_ptr <= rd_nxt[ADDR_W-1:0];
    end else if (rd_load) begin
      if (rd_busy) rd_load_pend <= 1'b1;
      else         rd_ptr       <= rd_min_addr;
    end
  end

  assign sdram_wr_req  = (state == WR_REQ);
  assign sdram_rd_req  = (state == RD_REQ);
  assign sdram_wr_addr = wr_ptr;
  assign sdram_rd_addr = rd_ptr;
  assign busy          = (state != IDLE);

endmodule

// File: doc/sdram_req_arbiter.md
Name: sdram_req_arbiter

Overview:
- Sits directly upstream of the SDRAM controller and drives its write and read request/ack handshake.
- Decides when a write burst or a read burst is issued:
  - write burst when the write FIFO holds enough data;
  - read burst when the read FIFO has enough free space.
- Supplies each burst's start address and length.
- Keeps circular write and read address pointers inside programmable address windows.

Parameters:
- ADDR_W, 24, SDRAM word-address width.
- LVL_W, 10, width of the FIFO level/room inputs and burst lengths.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- sdram_init_done  in  1  controller initialisation complete
- wr_fifo_level  in  LVL_W  words currently held in the write FIFO
- rd_fifo_room  in  LVL_W  free words in the read FIFO
- rd_enable  in  1  read path enabled
- wr_burst_len  in  LVL_W  write burst length, 1-512
- rd_burst_len  in  LVL_W  read burst length, 1-256
- wr_min_addr, wr_max_addr  in  ADDR_W  write window bounds, inclusive
- rd_min_addr, rd_max_addr  in  ADDR_W  read window bounds, inclusive
- wr_load  in  1  reset write pointer to wr_min_addr
- rd_load  in  1  reset read pointer to rd_min_addr
- sdram_wr_req  out  1  write request to the controller
- sdram_rd_req  out  1  read request to the controller
- sdram_wr_ack  in  1  high while the controller runs the write burst
- sdram_rd_ack  in  1  high while the controller runs the read burst
- sdram_wr_addr  out  ADDR_W  start address of the current or next write burst
- sdram_rd_addr  out  ADDR_W  start address of the current or next read burst
- sdram_wr_burst  out  LVL_W  write burst length latched at grant
- sdram_rd_burst  out  LVL_W  read burst length latched at grant
- busy  out  1  a transaction is in progress (state != IDLE)

Behaviour:
- Reset (rst=1 at a clk edge), regardless of state:
  - state=IDLE;
  - both req=0, busy=0;
  - wr_ptr=wr_min_addr, rd_ptr=rd_min_addr;
  - sdram_wr_burst=0, sdram_rd_burst=0;
  - last_grant=READ, so write wins the first tie.
- Eligibility (evaluated in IDLE only, all registered outputs):
  - wr_elig = init_done & wr_burst_len!=0 & wr_fifo_level>=wr_burst_len.
  - rd_elig = init_done & rd_enable & rd_burst_len!=0 & rd_fifo_room>=rd_burst_len.
  - init_done=0 means no request is ever issued.
- State machine (IDLE, WR_REQ, WR_ACT, RD_REQ, RD_ACT):
  - IDLE -> WR_REQ if wr_elig and (!rd_elig or last_grant==READ).
  - IDLE -> RD_REQ if rd_elig and (!wr_elig or last_grant==WRITE).
  - On a grant: latch the burst length into sdram_*_burst and set last_grant.
  - Latency: the req output rises 1 cycle after the eligible inputs are sampled in IDLE.
  - WR_REQ: sdram_wr_req=1 until sdram_wr_ack is sampled high, then req=0 and move to WR_ACT.
  - WR_ACT: wait for sdram_wr_ack sampled low (completion), then update the pointer and return to IDLE.
  - RD_REQ and RD_ACT behave identically using the read signals.
  - There is no timeout; a request is held indefinitely until acked.
- Only one req is high at any time; wr_req and rd_req are never asserted simultaneously.
- Pointer update on completion, computed ADDR_W+1 bits wide (write shown; read is identical with rd_* signals):
  - nxt = ptr + len, where len is the latched burst length.
  - If nxt + len > wr_max_addr + 1, ptr <= wr_min_addr; else ptr <= nxt.
  - Bursts therefore never cross wr_max_addr.
- sdram_wr_addr and sdram_rd_addr continuously reflect wr_ptr and rd_ptr; they are stable from grant to completion.
- wr_load / rd_load:
  - In IDLE, or in a state of the other direction: pointer <= min address on the next edge.
  - During the same direction's transaction: a load is pending and applied at completion, replacing the increment.
  - A load coinciding with the completion cycle also wins over the increment.
- Inputs arriving during a transaction:
  - FIFO level and room are not sampled.
  - Changes to burst length and address bounds take effect at the next grant or next pointer update.
- Ack glitches:
  - Ack high in IDLE is ignored.
  - Ack already high on entry to *_REQ is taken as the ack.

Test Plan:
- Reset, init_done=0, level=600, len=256 -> no req for 100 cycles; then init_done=1 -> wr_req=1 two edges later, wr_addr=0, wr_burst=256.
- Write window 0..1023, len 256, ack pulse 256 cycles per burst -> wr_addr sequence 0,256,512,768,0; req drops the cycle after ack is sampled high.
- Both eligible continuously (level=512, room=512, lens 256, rd_enable=1) -> grants alternate W,R,W,R, starting with W.
- rd_load asserted during a read burst with rd_ptr=512 -> the burst finishes at 512; the next read address is rd_min_addr=0x100, not 768.
- Window 0..1000, len 256 -> 0,256,512,0 (768+256>1001 forces wrap); len=0 or rd_enable=0 -> no request of that type.
- rst asserted during WR_ACT -> next cycle state IDLE, reqs 0, busy 0, pointers at min addresses.
